// File: rtl/cva6_mem_req_arbiter_if.sv
// Cache-to-memory request arbiter bus: requester handshakes, memory request
// port, response routing and status. slave = arbiter view, master = environment.
interface cva6_mem_req_arbiter_if #(
    parameter int unsigned NR_PORTS       = 3,
    parameter int unsigned MEM_TID_WIDTH  = 2,
    parameter int unsigned MAX_OUT_STORES = 7
);
    localparam int unsigned PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT_STORES + 1);

    logic [NR_PORTS-1:0]      req_valid_i;
    logic [NR_PORTS-1:0]      req_is_store_i;
    logic [NR_PORTS-1:0]      req_ready_o;
    logic                     mem_valid_o;
    logic                     mem_ready_i;
    logic [PORT_W-1:0]        mem_port_o;
    logic [MEM_TID_WIDTH-1:0] mem_tid_o;
    logic                     rtrn_valid_i;
    logic [MEM_TID_WIDTH-1:0] rtrn_tid_i;
    logic [NR_PORTS-1:0]      rtrn_valid_o;
    logic [CNT_W-1:0]         out_stores_o;
    logic                     idle_o;
    logic                     err_o;

    modport slave (
        input  req_valid_i, req_is_store_i, mem_ready_i, rtrn_valid_i, rtrn_tid_i,
        output req_ready_o, mem_valid_o, mem_port_o, mem_tid_o, rtrn_valid_o,
               out_stores_o, idle_o, err_o
    );

    modport master (
        output req_valid_i, req_is_store_i, mem_ready_i, rtrn_valid_i, rtrn_tid_i,
        input  req_ready_o, mem_valid_o, mem_port_o, mem_tid_o, rtrn_valid_o,
               out_stores_o, idle_o, err_o
    );
endinterface

// File: rtl/cva6_mem_req_arbiter.sv
// Round-robin memory request arbiter with TID allocation, store cap and response routing.
// Define CVA6_ARB_STORE_PRIO_EN to give the write buffer (last port) fixed priority.
module cva6_mem_req_arbiter #(
    parameter int unsigned NR_PORTS       = 3,
    parameter int unsigned MEM_TID_WIDTH  = 2,
    parameter int unsigned MAX_OUT_STORES = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cva6_mem_req_arbiter_if.slave bus
);
    localparam int unsigned NR_TID = 1 << MEM_TID_WIDTH;
    localparam int unsigned PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT_STORES + 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                           state_q, state_d;
    logic [PORT_W-1:0]                port_q, port_d, rr_q, rr_d;
    logic [MEM_TID_WIDTH-1:0]         tid_q, tid_d;
    logic                             st_pend_q, st_pend_d;
    logic [NR_TID-1:0]                busy_q, busy_d, tst_q, tst_d;
    logic [NR_TID-1:0][PORT_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic                     any_free, hs, rtrn_hit, st_ok;
    logic [NR_PORTS-1:0]      elig, rdy, rtrn_vld;
    logic [MEM_TID_WIDTH-1:0] free_tid;
    logic [PORT_W-1:0]        pick;
    logic                     pick_vld;
    int unsigned              k;

    assign any_free = ~&busy_q;
    assign st_ok    = (cnt_q < CNT_W'(MAX_OUT_STORES));
    assign rtrn_hit = bus.rtrn_valid_i & busy_q[bus.rtrn_tid_i];

    always_comb begin
        free_tid = '0;
        for (int i = int'(NR_TID) - 1; i >= 0; i--)
            if (!busy_q[i]) free_tid = MEM_TID_WIDTH'(i);
    end

    always_comb begin
        elig = '0;
        for (int p = 0; p < int'(NR_PORTS); p++)
            elig[p] = bus.req_valid_i[p] & any_free & (~bus.req_is_store_i[p] | st_ok);
    end

    // Scan ports starting at the RR pointer; first eligible wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        k        = 0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            k = 32'(rr_q) + i;
            if (k >= NR_PORTS) k = k - NR_PORTS;
            if (!pick_vld && elig[k[PORT_W-1:0]]) begin
                pick     = k[PORT_W-1:0];
                pick_vld = 1'b1;
            end
        end
`ifdef CVA6_ARB_STORE_PRIO_EN
        if (elig[NR_PORTS-1]) begin
            pick     = PORT_W'(NR_PORTS - 1);
            pick_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        tid_d     = tid_q;
        st_pend_d = st_pend_q;
        busy_d    = busy_q;
        tst_d     = tst_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        err_d     = err_q;
        hs        = 1'b0;

        if (bus.rtrn_valid_i) begin
            if (rtrn_hit) busy_d[bus.rtrn_tid_i] = 1'b0;
            else          err_d = 1'b1;
        end

        case (state_q)
            IDLE: if (pick_vld) begin
                port_d    = pick;
                tid_d     = free_tid;
                st_pend_d = bus.req_is_store_i[pick];
                state_d   = ISSUE;
            end
            ISSUE: if (bus.mem_ready_i) begin
                hs             = 1'b1;
                busy_d[tid_q]  = 1'b1;
                tst_d[tid_q]   = st_pend_q;
                owner_d[tid_q] = port_q;
`ifdef CVA6_ARB_STORE_PRIO_EN
                if (port_q != PORT_W'(NR_PORTS - 1))
`endif
                rr_d = (port_q == PORT_W'(NR_PORTS - 1)) ? '0 : port_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A store issued and a store retired in the same cycle cancel out.
    assign cnt_d = cnt_q + CNT_W'(hs & st_pend_q) - CNT_W'(rtrn_hit & tst_q[bus.rtrn_tid_i]);

    always_comb begin
        rdy = '0;
        if (hs) rdy[port_q] = 1'b1;
    end

    always_comb begin
        rtrn_vld = '0;
        if (rtrn_hit) rtrn_vld[owner_q[bus.rtrn_tid_i]] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            port_q    <= '0;
            rr_q      <= '0;
            tid_q     <= '0;
            st_pend_q <= 1'b0;
            busy_q    <= '0;
            tst_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            rr_q      <= rr_d;
            tid_q     <= tid_d;
            st_pend_q <= st_pend_d;
            busy_q    <= busy_d;
            tst_q     <= tst_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready_o  = rdy;
    assign bus.mem_valid_o  = (state_q == ISSUE);
    assign bus.mem_port_o   = port_q;
    assign bus.mem_tid_o    = tid_q;
    assign bus.rtrn_valid_o = rtrn_vld;
    assign bus.out_stores_o = cnt_q;
    assign bus.idle_o       = (state_q == IDLE) && !(|busy_q);
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// Table-driven bench for cva6_mem_req_arbiter (3 ports, 4 TIDs, store cap 2).
module tb_cva6_mem_req_arbiter;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    cva6_mem_req_arbiter_if #(.NR_PORTS(3), .MEM_TID_WIDTH(2), .MAX_OUT_STORES(2)) bus ();

    cva6_mem_req_arbiter #(.NR_PORTS(3), .MEM_TID_WIDTH(2), .MAX_OUT_STORES(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        bit         rst;
        logic [2:0] rv, st;
        logic       mr, rtv;
        logic [1:0] rtid;
        logic       emv;
        logic [1:0] eport, etid;
        logic [2:0] erdy, ertn;
        logic [1:0] ecnt;
        logic       eidle, eerr;
    } vec_t;

    vec_t vq[$];

    task automatic v(input bit rst, input logic [2:0] rv, st, input logic mr, rtv,
                     input logic [1:0] rtid, input logic emv, input logic [1:0] eport, etid,
                     input logic [2:0] erdy, ertn, input logic [1:0] ecnt,
                     input logic eidle, eerr);
        vec_t x;
        x.rst = rst; x.rv = rv; x.st = st; x.mr = mr; x.rtv = rtv; x.rtid = rtid;
        x.emv = emv; x.eport = eport; x.etid = etid; x.erdy = erdy; x.ertn = ertn;
        x.ecnt = ecnt; x.eidle = eidle; x.eerr = eerr;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int r, input logic [7:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, r, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rv, st, input logic mr, rtv, input logic [1:0] rtid);
        bus.req_valid_i    = rv;
        bus.req_is_store_i = st;
        bus.mem_ready_i    = mr;
        bus.rtrn_valid_i   = rtv;
        bus.rtrn_tid_i     = rtid;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        drive(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        tick();

`ifndef CVA6_ARB_STORE_PRIO_EN
        // Round-robin over all ports, pool exhaustion, late free, drain, error
        v(1, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  1, 0, 0, 3'b001, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  1, 1, 1, 3'b010, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  1, 2, 2, 3'b100, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  1, 0, 3, 3'b001, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b010, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b111, 3'b000, 1, 0, 0,  1, 1, 1, 3'b010, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 0,  0, 0, 0, 3'b000, 3'b001, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 2,  0, 0, 0, 3'b000, 3'b100, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 3,  0, 0, 0, 3'b000, 3'b001, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b010, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 1);
`else
        // Write buffer wins until capped, then icache is served
        v(1, 3'b101, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  1, 2, 0, 3'b100, 3'b000, 0, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  1, 2, 1, 3'b100, 3'b000, 1, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  1, 0, 2, 3'b001, 3'b000, 2, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  1, 0, 3, 3'b001, 3'b000, 2, 0, 0);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2, 0, 0);
`endif
        // Backpressure: port 1 held off for 5 cycles
        v(1, 3'b010, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        for (int i = 0; i < 5; i++)
        v(0, 3'b010, 3'b000, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b010, 3'b000, 1, 0, 0,  1, 1, 0, 3'b010, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 0, 1, 0,  0, 0, 0, 3'b000, 3'b010, 0, 0, 0);
        v(0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        // Store cap of 2, loads bypass, simultaneous issue+retire
        v(1, 3'b100, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  1, 2, 0, 3'b100, 3'b000, 0, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  1, 2, 1, 3'b100, 3'b000, 1, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 2, 0, 0);
        v(0, 3'b101, 3'b100, 1, 0, 0,  1, 0, 2, 3'b001, 3'b000, 2, 0, 0);
        v(0, 3'b100, 3'b100, 1, 1, 0,  0, 0, 0, 3'b000, 3'b100, 2, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  1, 2, 0, 3'b100, 3'b000, 1, 0, 0);
        v(0, 3'b100, 3'b100, 1, 1, 1,  0, 0, 0, 3'b000, 3'b100, 2, 0, 0);
        v(0, 3'b100, 3'b100, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
        v(0, 3'b100, 3'b100, 1, 1, 0,  1, 2, 1, 3'b100, 3'b100, 1, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 2,  0, 0, 0, 3'b000, 3'b001, 1, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b100, 1, 0, 0);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        // Routing of TID 1 owned by port 0, then response on a free TID
        v(1, 3'b010, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 0);
        v(0, 3'b010, 3'b000, 1, 0, 0,  1, 1, 0, 3'b010, 3'b000, 0, 0, 0);
        v(0, 3'b001, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b001, 3'b000, 1, 0, 0,  1, 0, 1, 3'b001, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b001, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 1, 1,  0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 0, 1);
        v(0, 3'b000, 3'b000, 1, 1, 0,  0, 0, 0, 3'b000, 3'b010, 0, 0, 1);
        v(0, 3'b000, 3'b000, 1, 0, 0,  0, 0, 0, 3'b000, 3'b000, 0, 1, 1);

        foreach (vq[r]) begin
            if (vq[r].rst) do_reset();
            drive(vq[r].rv, vq[r].st, vq[r].mr, vq[r].rtv, vq[r].rtid);
            #2;
            chk("mem_valid", r, 8'(bus.mem_valid_o), 8'(vq[r].emv));
            if (vq[r].emv) begin
                chk("mem_port", r, 8'(bus.mem_port_o), 8'(vq[r].eport));
                chk("mem_tid",  r, 8'(bus.mem_tid_o),  8'(vq[r].etid));
            end
            chk("req_ready",  r, 8'(bus.req_ready_o),  8'(vq[r].erdy));
            chk("rtrn_valid", r, 8'(bus.rtrn_valid_o), 8'(vq[r].ertn));
            chk("out_stores", r, 8'(bus.out_stores_o), 8'(vq[r].ecnt));
            chk("idle",       r, 8'(bus.idle_o),       8'(vq[r].eidle));
            chk("err",        r, 8'(bus.err_o),        8'(vq[r].eerr));
            tick();
        end

        // Async reset in the middle of a stalled ISSUE with a store outstanding
        do_reset();
        drive(3'b100, 3'b100, 1'b1, 1'b0, 2'd0);
        tick();
        tick();
        drive(3'b100, 3'b100, 1'b0, 1'b0, 2'd0);
        tick();
        #2;
        chk("pre_rst_valid", 900, 8'(bus.mem_valid_o),  8'd1);
        chk("pre_rst_cnt",   900, 8'(bus.out_stores_o), 8'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", 901, 8'(bus.mem_valid_o),  8'd0);
        chk("rst_idle",  901, 8'(bus.idle_o),       8'd1);
        chk("rst_cnt",   901, 8'(bus.out_stores_o), 8'd0);
        chk("rst_ready", 901, 8'(bus.req_ready_o),  8'd0);
        chk("rst_err",   901, 8'(bus.err_o),        8'd0);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        drive(3'b001, 3'b000, 1'b1, 1'b0, 2'd0);
        #2;
        chk("post_rst_valid", 902, 8'(bus.mem_valid_o), 8'd0);
        tick();
        #2;
        chk("post_rst_valid", 903, 8'(bus.mem_valid_o), 8'd1);
        chk("post_rst_port",  903, 8'(bus.mem_port_o),  8'd0);
        chk("post_rst_tid",   903, 8'(bus.mem_tid_o),   8'd0);
        chk("post_rst_ready", 903, 8'(bus.req_ready_o), 8'h01);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 2'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cva6_mem_req_arbiter.md
Name: cva6_mem_req_arbiter

Overview:
- Shares the single cache-to-memory request port between the icache refill, the dcache read-miss path and the write-through dcache write buffer.
- Round-robin arbitration with transaction-ID (TID) allocation from a 2^MemTidWidth pool.
- Caps outstanding stores at MaxOutstandingStores and routes each memory response back to its originating requester by TID.
- Sits between the cache subsystem and the AXI/NoC adapter; carries control only (payload muxed externally by mem_port_o).

Parameters:
- NR_PORTS, 3, number of requesters (port 0 = icache, 1 = dcache read, 2 = dcache write buffer)
- MEM_TID_WIDTH, 2, TID width; pool size NR_TID = 2^MEM_TID_WIDTH
- MAX_OUT_STORES, 7, maximum stores in flight (counter width $clog2(MAX_OUT_STORES+1))
- PORT_W, $clog2(NR_PORTS), port index width (derived, not overridable)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_PORTS  per-port request valid
- req_is_store_i  in  NR_PORTS  request is a store (consumes store credit)
- req_ready_o  out  NR_PORTS  one-hot grant accepted this cycle
- mem_valid_o  out  1  request to memory adapter
- mem_ready_i  in  1  adapter accepts request
- mem_port_o  out  PORT_W  granted port index (payload mux select)
- mem_tid_o  out  MEM_TID_WIDTH  TID attached to the request
- rtrn_valid_i  in  1  memory response valid (always accepted)
- rtrn_tid_i  in  MEM_TID_WIDTH  TID of response
- rtrn_valid_o  out  NR_PORTS  one-hot response routed to owner port
- out_stores_o  out  $clog2(MAX_OUT_STORES+1)  current outstanding store count
- idle_o  out  1  no TID allocated and FSM in IDLE
- err_o  out  1  sticky: response received for an unallocated TID

Behaviour:
- Reset (async on rst_ni low): FSM IDLE, all TIDs free, RR pointer = 0, store count 0, err_o 0, idle_o 1; mem_valid_o, req_ready_o and rtrn_valid_o all 0.
- Eligible port: req_valid_i set AND a TID is free AND (not a store OR out_stores_o < MAX_OUT_STORES).
- FSM IDLE: if any port is eligible, pick by round-robin starting at RR pointer. Latch the port and the lowest-index free TID, then go to ISSUE.
- FSM ISSUE: mem_valid_o = 1; mem_port_o and mem_tid_o hold stable until mem_ready_i.
  - On mem_valid_o & mem_ready_i: req_ready_o[port] pulses for 1 cycle; the TID is marked busy with its owner and is_store.
  - Store count increments on a store handshake; RR pointer = port+1 mod NR_PORTS; return to IDLE.
- Minimum issue latency: 1 cycle from req_valid_i to mem_valid_o. Sustained throughput is 1 request per 2 cycles.
- Requesters must hold req_valid_i and the payload until req_ready_o. Deassertion before grant is a protocol violation; the arbiter still completes the latched request.
- Response handling:
  - rtrn_valid_i with a busy TID: combinationally drive rtrn_valid_o[owner] = 1 in the same cycle.
  - The TID is freed next cycle; the store count decrements if the TID's is_store bit is set.
  - rtrn_valid_i with a free TID: no routing, err_o set until reset.
- Simultaneous issue handshake and response in one cycle: both take effect; the store count nets to unchanged if both are stores.
- A TID freed in cycle N is not allocatable before cycle N+1.
- TID pool empty: no port eligible; FSM stays IDLE and mem_valid_o = 0.
- Store count at MAX_OUT_STORES: stores blocked, loads and icache still served; no overflow or underflow possible.
- idle_o = (FSM == IDLE) AND no busy TID.

Optional Feature:
- Macro CVA6_ARB_STORE_PRIO_EN.
- Defined: port NR_PORTS-1 (write buffer) has fixed priority over round-robin whenever eligible. The RR pointer only advances on grants to other ports.
- Undefined: pure round-robin across all ports.

Test Plan:
- Reset idle: rst_ni low mid-ISSUE, then released -> mem_valid_o 0, idle_o 1, out_stores_o 0, TIDs free.
- Round-robin: all 3 ports valid continuously, mem_ready_i = 1, no store limit -> grants 0,1,2,0 with TIDs 0,1,2,3, then stall until a response frees a TID.
- Backpressure: port 1 request, mem_ready_i low 5 cycles -> mem_valid_o, mem_port_o = 1 and mem_tid_o stable for 6 cycles; req_ready_o[1] pulses once.
- Store cap: MAX_OUT_STORES = 2, NR_TID = 4, port 2 issues 2 stores, a 3rd is pending -> no grant until a response for a store TID; out_stores_o goes 2 -> 1 -> 2.
- Response routing and error: response on TID 1 (owner port 0) -> rtrn_valid_o = 3'b001 same cycle. A later response on free TID 1 -> err_o = 1, rtrn_valid_o = 0.
- With CVA6_ARB_STORE_PRIO_EN: ports 0 and 2 valid continuously -> port 2 granted until blocked by store cap, then port 0 granted.
